// File: rtl/mat_stream_host_if.sv
// Bundles the load/readback/control strobes and both AXI-Stream channels of mat_stream_host.
// Carries no logic of its own.
// The master modport is the host endpoint. The slave modport is its peer (controller plus accelerator).
interface mat_stream_host_if #(
    parameter int DIM_LOG    = 1,
    parameter int DATA_WIDTH = 32
);
    localparam int SIZE_LOG = 2 * DIM_LOG;

    // operand load and result readback
    logic                    ld_we;
    logic                    ld_sel;
    logic [SIZE_LOG-1:0]     ld_addr;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [SIZE_LOG-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;

    // transfer control and status
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    err_tlast;

    // operand stream towards the accelerator
    logic                    m00_axis_tvalid;
    logic [DATA_WIDTH-1:0]   m00_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
    logic                    m00_axis_tlast;
    logic                    m00_axis_tready;

    // result stream from the accelerator
    logic                    s00_axis_tvalid;
    logic [DATA_WIDTH-1:0]   s00_axis_tdata;
    logic                    s00_axis_tlast;
    logic                    s00_axis_tready;

    modport master (
        input  ld_we, ld_sel, ld_addr, ld_data, rd_addr, start,
        output rd_data, busy, done, err_tlast,
        output m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast,
        input  m00_axis_tready,
        input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
        output s00_axis_tready
    );

    modport slave (
        output ld_we, ld_sel, ld_addr, ld_data, rd_addr, start,
        input  rd_data, busy, done, err_tlast,
        input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast,
        output m00_axis_tready,
        output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
        input  s00_axis_tready
    );
endinterface

// File: rtl/mat_stream_host.sv
// Host endpoint for mat_mul. It streams A then B row-major on m00 and captures SIZE result words from s00.
// Latency: the first m00 tvalid appears the cycle after start. Streaming is 1 word/cycle, or 1 word per 2 cycles with MM_TX_THROTTLE_EN.
// Backpressure: m00 data and last are held while tready=0. s00 tready is high only in RECV.
// Optional macro MM_TX_THROTTLE_EN inserts one idle (tvalid=0) cycle after every accepted m00 beat.
module mat_stream_host #(
    parameter int DIM_LOG    = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_aresetn,
    mat_stream_host_if.master bus
);
    localparam int DIM      = 1 << DIM_LOG;
    localparam int SIZE     = DIM * DIM;
    localparam int SIZE_LOG = 2 * DIM_LOG;

    typedef logic [SIZE_LOG:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(SIZE - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

`ifdef MM_TX_THROTTLE_EN
    localparam bit THROTTLE = 1'b1;
`else
    localparam bit THROTTLE = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   err_q, err_d;
    logic   gap_q, gap_d;

    logic [DATA_WIDTH-1:0] a_mem_q [SIZE];
    logic [DATA_WIDTH-1:0] b_mem_q [SIZE];
    logic [DATA_WIDTH-1:0] r_mem_q [SIZE];

    logic                busy;
    logic                tx_vld;
    logic                tx_last;
    logic                rx_rdy;
    logic                m_beat;
    logic                s_beat;
    logic                cnt_is_last;
    logic [SIZE_LOG-1:0] idx;

    assign idx         = cnt_q[SIZE_LOG-1:0];
    assign cnt_is_last = (cnt_q == CNT_LAST);

    // State, beat counter, sticky tlast error and throttle gap flag
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic and handshake outputs. The counter restarts at zero on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        gap_d   = 1'b0;
        busy    = (state_q == ST_SEND_A) || (state_q == ST_SEND_B) || (state_q == ST_RECV);
        tx_vld  = ((state_q == ST_SEND_A) || (state_q == ST_SEND_B)) && !gap_q;
        tx_last = (state_q == ST_SEND_B) && cnt_is_last;
        rx_rdy  = (state_q == ST_RECV);
        m_beat  = tx_vld && bus.m00_axis_tready;
        s_beat  = rx_rdy && bus.s00_axis_tvalid;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_SEND_A;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_SEND_A: begin
                if (m_beat) begin
                    gap_d = THROTTLE;
                    if (cnt_is_last) begin
                        state_d = ST_SEND_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_SEND_B: begin
                if (m_beat) begin
                    gap_d = THROTTLE;
                    if (cnt_is_last) begin
                        state_d = ST_RECV;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_RECV: begin
                if (s_beat) begin
                    // A last flag must appear on the final result word and on no other word.
                    if (bus.s00_axis_tlast != cnt_is_last) begin
                        err_d = 1'b1;
                    end
                    if (cnt_is_last) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Operand storage. Writes are dropped while a transfer is in flight.
    // A write in the same cycle as start lands before A[0] is first presented.
    always_ff @(posedge s00_axi_aclk) begin
        if (bus.ld_we && !busy) begin
            if (bus.ld_sel) begin
                b_mem_q[bus.ld_addr] <= bus.ld_data;
            end else begin
                a_mem_q[bus.ld_addr] <= bus.ld_data;
            end
        end
    end

    // Result capture. Each accepted result beat lands at the current beat index.
    always_ff @(posedge s00_axi_aclk) begin
        if (s_beat) begin
            r_mem_q[idx] <= bus.s00_axis_tdata;
        end
    end

    assign bus.m00_axis_tvalid = tx_vld;
    assign bus.m00_axis_tdata  = (state_q == ST_SEND_B) ? b_mem_q[idx] : a_mem_q[idx];
    assign bus.m00_axis_tstrb  = '1;
    assign bus.m00_axis_tlast  = tx_last;
    assign bus.s00_axis_tready = rx_rdy;
    assign bus.busy            = busy;
    assign bus.done            = (state_q == ST_DONE);
    assign bus.err_tlast       = err_q;
    assign bus.rd_data         = r_mem_q[bus.rd_addr];
endmodule

// File: tb/tb_mat_stream_host.sv
// Bench for mat_stream_host with DIM_LOG=1. It uses directed vector tables and hand-written reset and stall sequences.
// The bench also acts as the accelerator: it returns the A*B product computed from the loaded operands, under random handshakes.
module tb_mat_stream_host;
    localparam int DIM_LOG = 1;
    localparam int DIM     = 1 << DIM_LOG;
    localparam int SIZE    = DIM * DIM;
    localparam int SL      = 2 * DIM_LOG;
    localparam int DW      = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mat_stream_host_if #(.DIM_LOG(DIM_LOG), .DATA_WIDTH(DW)) bus ();

    mat_stream_host #(.DIM_LOG(DIM_LOG), .DATA_WIDTH(DW)) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] mA [SIZE];
    logic [DW-1:0] mB [SIZE];

    typedef struct {
        logic          rdy;
        logic          start;
        logic [DW-1:0] exp_tdata;
        logic          exp_tlast;
    } tx_vec_t;

    typedef struct {
        logic          vld;
        logic [DW-1:0] dat;
        logic          lst;
        logic          we;
        logic          exp_err;
    } rx_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Reference product from matrix arithmetic on the bench copies of A and B.
    function automatic logic [DW-1:0] mm(input int idx);
        logic [DW-1:0] s;
        int r;
        int c;
        r = idx / DIM;
        c = idx % DIM;
        s = '0;
        for (int k = 0; k < DIM; k++) s = s + mA[r*DIM+k] * mB[k*DIM+c];
        return s;
    endfunction

    task automatic load(input logic sel, input int addr, input logic [DW-1:0] d);
        @(negedge clk);
        bus.ld_we   = 1'b1;
        bus.ld_sel  = sel;
        bus.ld_addr = SL'(addr);
        bus.ld_data = d;
        @(posedge clk);
        #1 bus.ld_we = 1'b0;
        if (sel) mB[addr] = d;
        else     mA[addr] = d;
    endtask

    task automatic pulse_start(input bit wr, input logic [DW-1:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        if (wr) begin
            bus.ld_we   = 1'b1;
            bus.ld_sel  = 1'b0;
            bus.ld_addr = '0;
            bus.ld_data = d;
            mA[0]       = d;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.ld_we = 1'b0;
    endtask

    // One full transfer. It checks the operand stream against A++B, feeds back A*B, and then checks status and readback.
    task automatic run_txn(input int unsigned ready_pct, input int unsigned valid_pct, input int bad, input bit wr);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] res [SIZE];
        int  k;
        int  j;
        int  cyc;
        int  first;
        int  last;
        bit  rdy;
        bit  v;
        bit  prev;
        pulse_start(wr, $urandom());
        exp_q = {};
        for (int i = 0; i < SIZE; i++) exp_q.push_back(mA[i]);
        for (int i = 0; i < SIZE; i++) exp_q.push_back(mB[i]);
        for (int i = 0; i < SIZE; i++) res[i] = mm(i);
        k = 0; cyc = 0; first = -1; last = -1; prev = 0;
        chk("start_clears_done", 32'(bus.done), 32'(0));
        chk("start_clears_err", 32'(bus.err_tlast), 32'(0));
        while (k < 2*SIZE && cyc < 400) begin
            @(negedge clk);
            cyc++;
`ifdef MM_TX_THROTTLE_EN
            if (prev) chk("tx_gap", 32'(bus.m00_axis_tvalid), 32'(0));
`endif
            prev = 0;
            rdy = ($urandom_range(0, 99) < ready_pct);
            bus.m00_axis_tready = rdy;
            if (bus.m00_axis_tvalid) begin
                chk("tx_tdata", bus.m00_axis_tdata, exp_q[k]);
                chk("tx_tlast", 32'(bus.m00_axis_tlast), 32'(k == 2*SIZE-1));
                if (rdy) begin
                    if (first < 0) first = cyc;
                    last = cyc;
                    k++;
                    prev = 1;
                end
            end
        end
        if (k < 2*SIZE) chk("tx_timeout", 32'(k), 32'(2*SIZE));
        if (ready_pct >= 100) begin
`ifdef MM_TX_THROTTLE_EN
            chk("tx_span", 32'(last - first + 1), 32'(4*SIZE-1));
`else
            chk("tx_span", 32'(last - first + 1), 32'(2*SIZE));
`endif
        end
        j = 0; cyc = 0;
        while (j < SIZE && cyc < 400) begin
            @(negedge clk);
            cyc++;
            chk("rx_tready", 32'(bus.s00_axis_tready), 32'(1));
            chk("rx_tvalid_m00_low", 32'(bus.m00_axis_tvalid), 32'(0));
            v = ($urandom_range(0, 99) < valid_pct);
            bus.s00_axis_tvalid = v;
            bus.s00_axis_tdata  = v ? res[j] : $urandom();
            bus.s00_axis_tlast  = v ? ((j == SIZE-1) != (j == bad)) : 1'($urandom_range(0, 1));
            if (v) j++;
        end
        if (j < SIZE) chk("rx_timeout", 32'(j), 32'(SIZE));
        // Offer one extra result beat in DONE. It must not be accepted.
        @(negedge clk);
        bus.s00_axis_tvalid = 1'b1;
        bus.s00_axis_tdata  = 32'hDEAD_BEEF;
        bus.s00_axis_tlast  = 1'b1;
        chk("done", 32'(bus.done), 32'(1));
        chk("done_busy", 32'(bus.busy), 32'(0));
        chk("done_tready", 32'(bus.s00_axis_tready), 32'(0));
        chk("done_err", 32'(bus.err_tlast), 32'(bad >= 0 && bad < SIZE));
        @(negedge clk);
        bus.s00_axis_tvalid = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            bus.rd_addr = SL'(i);
            #1 chk("rd_data", bus.rd_data, res[i]);
        end
    endtask

    tx_vec_t tx_tab [11];
    rx_vec_t rx_tab [5];

    initial begin
        int k;
        int cyc;
        bus.ld_we = 0; bus.ld_sel = 0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.rd_addr = '0; bus.start = 0; bus.m00_axis_tready = 0;
        bus.s00_axis_tvalid = 0; bus.s00_axis_tdata = '0; bus.s00_axis_tlast = 0;

        // A stall of three cycles on A[2], plus a start pulse during SEND_B that must be ignored.
        tx_tab = '{
            '{1'b1, 1'b0, 32'd1, 1'b0}, '{1'b1, 1'b0, 32'd2, 1'b0},
            '{1'b0, 1'b0, 32'd3, 1'b0}, '{1'b0, 1'b0, 32'd3, 1'b0},
            '{1'b0, 1'b0, 32'd3, 1'b0}, '{1'b1, 1'b0, 32'd3, 1'b0},
            '{1'b1, 1'b0, 32'd4, 1'b0}, '{1'b1, 1'b0, 32'd5, 1'b0},
            '{1'b1, 1'b1, 32'd6, 1'b0}, '{1'b1, 1'b0, 32'd7, 1'b0},
            '{1'b1, 1'b0, 32'd8, 1'b1}};
        // The result has a stray tlast on index 1, and a load of A[0]=99 is attempted mid-RECV.
        rx_tab = '{
            '{1'b1, 32'd19, 1'b0, 1'b0, 1'b0}, '{1'b1, 32'd22, 1'b1, 1'b0, 1'b0},
            '{1'b0, 32'd0,  1'b0, 1'b1, 1'b1}, '{1'b1, 32'd43, 1'b0, 1'b0, 1'b1},
            '{1'b1, 32'd50, 1'b1, 1'b0, 1'b1}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_err", 32'(bus.err_tlast), 32'(0));
        chk("rst_tvalid", 32'(bus.m00_axis_tvalid), 32'(0));
        chk("rst_tlast", 32'(bus.m00_axis_tlast), 32'(0));
        chk("rst_s_tready", 32'(bus.s00_axis_tready), 32'(0));
        chk("tstrb", 32'(bus.m00_axis_tstrb), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < SIZE; i++) load(1'b0, i, DW'(i + 1));
        for (int i = 0; i < SIZE; i++) load(1'b1, i, DW'(i + 5));

`ifndef MM_TX_THROTTLE_EN
        pulse_start(1'b0, '0);
        for (int r = 0; r < 11; r++) begin
            @(negedge clk);
            bus.m00_axis_tready = tx_tab[r].rdy;
            bus.start           = tx_tab[r].start;
            chk("tab_tvalid", 32'(bus.m00_axis_tvalid), 32'(1));
            chk("tab_tdata", bus.m00_axis_tdata, tx_tab[r].exp_tdata);
            chk("tab_tlast", 32'(bus.m00_axis_tlast), 32'(tx_tab[r].exp_tlast));
            chk("tab_busy", 32'(bus.busy), 32'(1));
        end
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            chk("tab_rx_tready", 32'(bus.s00_axis_tready), 32'(1));
            chk("tab_rx_done", 32'(bus.done), 32'(0));
            chk("tab_rx_err", 32'(bus.err_tlast), 32'(rx_tab[r].exp_err));
            bus.start           = 1'b0;
            bus.s00_axis_tvalid = rx_tab[r].vld;
            bus.s00_axis_tdata  = rx_tab[r].dat;
            bus.s00_axis_tlast  = rx_tab[r].lst;
            bus.ld_we           = rx_tab[r].we;
            bus.ld_sel          = 1'b0;
            bus.ld_addr         = '0;
            bus.ld_data         = 32'd99;
        end
        @(negedge clk);
        bus.s00_axis_tvalid = 1'b0;
        bus.ld_we           = 1'b0;
        chk("tab_done", 32'(bus.done), 32'(1));
        chk("tab_err_sticky", 32'(bus.err_tlast), 32'(1));
        for (int i = 0; i < SIZE; i++) begin
            bus.rd_addr = SL'(i);
            #1 chk("tab_rd_data", bus.rd_data, mm(i));
        end
`endif

        // Clean full-rate run. The first word must still be A[0]=1.
        run_txn(100, 100, -1, 1'b0);

        // Apply reset mid-stream at SEND_B cnt=2, then restart from A[0].
        pulse_start(1'b0, '0);
        bus.m00_axis_tready = 1'b1;
        k = 0; cyc = 0;
        while (k < SIZE + 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (bus.m00_axis_tvalid) k++;
        end
        @(negedge clk);
        chk("pre_rst_tdata", bus.m00_axis_tdata, mB[2]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(bus.m00_axis_tvalid), 32'(0));
        chk("mid_rst_busy", 32'(bus.busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(100, 100, -1, 1'b0);

        // Randomized transfers checked against the matrix product.
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < SIZE; i++) load(1'b0, i, $urandom());
            for (int i = 0; i < SIZE; i++) load(1'b1, i, $urandom());
            run_txn($urandom_range(30, 100), $urandom_range(30, 100),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SIZE-1)) : -1,
                    1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
